uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: UART_RX_CORE

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  oversampling clock, equal to Prescale x baud rate.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RX_IN  input  1  serial line; idles high.
REQ-005 SHALL have port PAR_EN  input  1  1 = parity bit present in the frame.
REQ-006 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port Prescale  input  6  oversampling ratio; the supported values are 8, 16 and 32.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last received data word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 SHALL have port par_err  output  1  one-cycle parity-error pulse.
REQ-011 SHALL have port stp_err  output  1  one-cycle stop-error pulse.
REQ-012 SHALL have port rx_busy  output  1  high while a frame is in progress.

Function
REQ-013 SHALL treat any Prescale value other than 16 or 32 as 8.
REQ-014 SHALL implement an FSM with the states IDLE, START, DATA, PARITY and STOP; rx_busy SHALL be high in every state except IDLE.
REQ-015 SHALL use an edge counter, edge_cnt, that spans 0..P-1 per bit, where P is the effective Prescale; the cycle in IDLE that sees RX_IN=0 SHALL count as edge 0 of the start bit.
REQ-016 On that start-detection cycle, the block SHALL latch PAR_EN, PAR_TYP and the effective Prescale, and hold them for the whole frame.
REQ-017 SHALL take samples at edge_cnt = P/2-1, P/2 and P/2+1, and SHALL use the 2-of-3 majority as the bit value.
REQ-018 START: at edge P-1, a majority of 1 (glitch) SHALL return the FSM to IDLE with no output pulse; a majority of 0 SHALL move it to DATA.
REQ-019 DATA: the block SHALL receive DATA_WIDTH bits LSB first, using a bit counter from 0 to DATA_WIDTH-1.
REQ-020 At edge P-1 of the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, and to STOP otherwise.
REQ-021 PARITY: the expected parity SHALL be the XOR of the data bits, inverted when PAR_TYP=1.
REQ-022 At edge P-1 of PARITY, a mismatch SHALL pulse par_err for one cycle and mark the frame as bad.
REQ-023 STOP: at edge P-1, a sampled 0 SHALL pulse stp_err for one cycle.
REQ-024 At edge P-1 of STOP, if stop=1 and the frame is not bad, the block SHALL load P_DATA and pulse data_valid in the same cycle.
REQ-025 The FSM SHALL then return to IDLE.
REQ-026 P_DATA SHALL hold its value between valid frames and SHALL never change on a bad frame.
REQ-027 data_valid, par_err and stp_err SHALL be registered and SHALL each be high for exactly 1 CLK.
REQ-028 When a parity error and a stop error occur in the same frame, both pulses SHALL be emitted (par_err first, then stp_err at the end of STOP), and data_valid SHALL stay 0.
REQ-029 Back-to-back frames: RX_IN=0 on the cycle after the last stop edge SHALL be detected as a new start, with no idle gap required.
REQ-030 A change to Prescale, PAR_EN or PAR_TYP mid-frame SHALL have no effect until the next start detection.
REQ-031 Frame length in CLK cycles SHALL be P x (DATA_WIDTH + 2 + PAR_EN).
REQ-032 data_valid SHALL rise (DATA_WIDTH + 2 + PAR_EN) x P - 1 cycles after the start-detection cycle.

Reset
REQ-033 While RST=0, the block SHALL asynchronously force the FSM to IDLE and clear all counters and the bad-frame flag.
REQ-034 While RST=0, the block SHALL force P_DATA=0, data_valid=0, par_err=0, stp_err=0 and rx_busy=0.
REQ-035 A reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-036 After reset release, the first start bit SHALL be received correctly.

Verification
REQ-037 Prescale=8, PAR_EN=0: frame 0xA5 -> after 79 cycles, data_valid pulses with P_DATA=0xA5 and no errors.
REQ-038 Prescale=16, PAR_EN=1, PAR_TYP=0: data 0x37 with parity bit 1 -> P_DATA=0x37 and par_err=0. The same frame with parity bit 0 -> par_err pulses and P_DATA keeps its old value.
REQ-039 Prescale=32, PAR_TYP=1: data 0x00 with stop bit forced 0 -> stp_err pulses, data_valid=0, and the FSM returns to IDLE.
REQ-040 Start glitch: RX_IN low for 2 cycles at Prescale=8 -> the FSM returns to IDLE at edge 7 with no pulses and rx_busy low afterwards.
REQ-041 Back-to-back frames 0x12 and 0x34 at Prescale=16 with no idle gap -> two data_valid pulses exactly 160 cycles apart.
REQ-042 RST asserted during bit 4 of 0xFF -> outputs 0 immediately; a following 0x5A frame is received correctly; Prescale changed mid-frame leaves that frame's timing unchanged.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
//   Each bit spans P clocks (P = 8, 16 or 32, chosen from Prescale at start
//   detection). The bit value is the 2-of-3 majority of samples taken at
//   edges P/2-1, P/2 and P/2+1; the decision is acted on at edge P-1.
// Ports:
//   CLK        oversampling clock (Prescale x baud)
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idles high
//   PAR_EN     parity bit present (latched per frame)
//   PAR_TYP    0 = even, 1 = odd parity (latched per frame)
//   Prescale   oversampling ratio; 16 and 32 honoured, anything else means 8
//   P_DATA     last good data word
//   data_valid one-cycle pulse when P_DATA updates
//   par_err    one-cycle parity-error pulse
//   stp_err    one-cycle stop-error pulse
//   rx_busy    high while a frame is in progress
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN=0 (that cycle is edge 0 of start)
// START  | validating the start bit; majority 1 means glitch, back to IDLE
// DATA   | shifting in DATA_WIDTH bits, LSB first
// PARITY | checking the parity bit against the received data
// STOP   | checking the stop bit, then publishing or dropping the word
module uart_rx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  rx_busy
);
    localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  bad_q, bad_d;
    logic                  pen_q, pen_d;
    logic                  ptyp_q, ptyp_d;
    logic [5:0]            presc_q, presc_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [5:0] presc_eff;
    logic [5:0] half;
    logic       last_edge;
    logic       maj;
    logic       exp_par;

    assign presc_eff = (Prescale == 6'd16) ? 6'd16 :
                       (Prescale == 6'd32) ? 6'd32 : 6'd8;
    assign half      = presc_q >> 1;
    assign last_edge = (edge_q == presc_q - 6'd1);
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);
    assign exp_par   = (^shift_q) ^ ptyp_q;

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        bad_d   = bad_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        presc_d = presc_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            if (edge_q == half - 6'd1) samp_d[0] = RX_IN;
            if (edge_q == half)        samp_d[1] = RX_IN;
            if (edge_q == half + 6'd1) samp_d[2] = RX_IN;
            edge_d = last_edge ? 6'd0 : edge_q + 6'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    // This cycle is edge 0 of the start bit.
                    state_d = ST_START;
                    edge_d  = 6'd1;
                    bit_d   = '0;
                    bad_d   = 1'b0;
                    pen_d   = PAR_EN;
                    ptyp_d  = PAR_TYP;
                    presc_d = presc_eff;
                end
            end
            ST_START: begin
                if (last_edge) state_d = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (last_edge) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = maj;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (last_edge) begin
                    if (maj != exp_par) begin
                        pe_d  = 1'b1;
                        bad_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (last_edge) begin
                    if (!maj) begin
                        se_d = 1'b1;
                    end else if (!bad_q) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            bad_q   <= 1'b0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            presc_q <= 6'd8;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            bad_q   <= bad_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            presc_q <= presc_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives whole UART frames bit-by-bit and predicts, per
// frame, on which clock the pulses fire and how long rx_busy stays high.
// A negedge process compares every output on every cycle against that
// prediction; a few literal checks pin the prediction itself.
module tb_uart_rx_core;
    localparam int MAXC = 40000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, rx_busy;

    uart_rx_core #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .Prescale(Prescale), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
        .rx_busy(rx_busy)
    );

    always #5 CLK = ~CLK;

    bit         exp_dv   [MAXC];
    bit         exp_pe   [MAXC];
    bit         exp_se   [MAXC];
    bit         exp_busy [MAXC];
    logic [7:0] exp_data [MAXC];

    int         negcnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         dv_last = 0, dv_prev = 0;
    int         n_dv_seen = 0, n_pe_seen = 0, n_se_seen = 0;
    logic [7:0] model_pdata = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, negcnt);
        end
    endtask

    function automatic int eff(input logic [5:0] p);
        if (p == 6'd16) return 16;
        if (p == 6'd32) return 32;
        return 8;
    endfunction

    always @(negedge CLK) begin
        bit e_dv, e_pe, e_se, e_busy;
        negcnt++;
        e_dv = 0; e_pe = 0; e_se = 0; e_busy = 0;
        if (!RST) begin
            model_pdata = 8'h00;
        end else if (negcnt < MAXC) begin
            e_dv = exp_dv[negcnt]; e_pe = exp_pe[negcnt];
            e_se = exp_se[negcnt]; e_busy = exp_busy[negcnt];
            if (e_dv) model_pdata = exp_data[negcnt];
        end
        chk("data_valid", data_valid, e_dv);
        chk("par_err", par_err, e_pe);
        chk("stp_err", stp_err, e_se);
        chk("rx_busy", rx_busy, e_busy);
        chk("P_DATA", P_DATA, model_pdata);
        if (data_valid === 1'b1) begin
            dv_prev = dv_last; dv_last = negcnt; n_dv_seen++;
        end
        if (par_err === 1'b1) n_pe_seen++;
        if (stp_err === 1'b1) n_se_seen++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic do_reset();
        for (int i = negcnt + 1; i < MAXC && i < negcnt + 500; i++) begin
            exp_dv[i] = 0; exp_pe[i] = 0; exp_se[i] = 0; exp_busy[i] = 0;
        end
        RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        chk("rst_pdata_now", P_DATA, 8'h00);
        chk("rst_busy_now", rx_busy, 1'b0);
        chk("rst_dv_now", data_valid, 1'b0);
        tick(3);
        RST = 1'b1;
    endtask

    // Entered and left at posedge+1. s_o is the negedge count when the start
    // bit is put on the line; the DUT detects it at the following posedge.
    task automatic send_frame(input logic [7:0] d, input logic [5:0] presc,
                              input logic pen, input logic ptyp,
                              input logic bad_par, input logic stop_bit,
                              input int chg_bit, input int abort_bit,
                              output int s_o);
        int   p, n, s;
        logic par;
        logic bits[$];
        Prescale = presc; PAR_EN = pen; PAR_TYP = ptyp;
        p = eff(presc);
        n = 10 + int'(pen);
        par = (^d) ^ ptyp ^ bad_par;
        s = negcnt;
        s_o = s;
        for (int i = s + 2; i <= s + n * p && i < MAXC; i++) exp_busy[i] = 1;
        if (s + 1 + n * p < MAXC) begin
            if (pen && bad_par) exp_pe[s + 1 + 10 * p] = 1;
            if (!stop_bit) exp_se[s + 1 + n * p] = 1;
            else if (!(pen && bad_par)) begin
                exp_dv[s + 1 + n * p] = 1;
                exp_data[s + 1 + n * p] = d;
            end
        end
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(par);
        bits.push_back(stop_bit);
        for (int i = 0; i < bits.size(); i++) begin
            RX_IN = bits[i];
            if (i == chg_bit) begin
                Prescale = 6'($urandom);
                PAR_EN = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            if (i == abort_bit) begin
                tick(p / 2);
                do_reset();
                return;
            end
            tick(p);
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        int s, pe0, se0, dv0;
        logic [7:0] d;
        logic [5:0] pr;

        tick(4);
        RST = 1'b1;
        tick(3);

        // 0xA5 at P=8, no parity: valid 79 cycles after start detection.
        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, s);
        @(negedge CLK); #1;
        chk("a5_latency", dv_last - (s + 2), 79);
        chk("a5_pdata", P_DATA, 8'hA5);
        tick(3);

        // 0x37 at P=16 even parity: good, then corrupted parity bit.
        send_frame(8'h37, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, s);
        tick(2);
        chk("p37_pdata", P_DATA, 8'h37);
        pe0 = n_pe_seen;
        send_frame(8'h37, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, s);
        tick(2);
        chk("p37_bad_pe", n_pe_seen - pe0, 1);
        chk("p37_bad_keep", P_DATA, 8'h37);

        // 0x00 at P=32 odd parity with stop bit forced low.
        se0 = n_se_seen; dv0 = n_dv_seen;
        send_frame(8'h00, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, s);
        tick(2);
        chk("stop_err_cnt", n_se_seen - se0, 1);
        chk("stop_err_nodv", n_dv_seen - dv0, 0);
        chk("stop_err_idle", rx_busy, 1'b0);

        // Start glitch: two low cycles at P=8.
        Prescale = 6'd8;
        s = negcnt;
        for (int i = s + 2; i <= s + 8; i++) exp_busy[i] = 1;
        RX_IN = 1'b0;
        tick(2);
        RX_IN = 1'b1;
        tick(10);
        chk("glitch_idle", rx_busy, 1'b0);

        // Back-to-back 0x12, 0x34 at P=16.
        send_frame(8'h12, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, s);
        send_frame(8'h34, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, s);
        @(negedge CLK); #1;
        chk("b2b_gap", dv_last - dv_prev, 160);
        chk("b2b_pdata", P_DATA, 8'h34);
        tick(3);

        // Reset during data bit 4 of 0xFF, then 0x5A with Prescale changed mid-frame.
        send_frame(8'hFF, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5, s);
        tick(2);
        send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1, s);
        @(negedge CLK); #1;
        chk("5a_latency", dv_last - (s + 2), 79);
        chk("5a_pdata", P_DATA, 8'h5A);
        tick(3);

        // Randomized frames with random settings, gaps and mid-frame changes.
        for (int f = 0; f < 40; f++) begin
            int chg, gap;
            logic pen, ptyp, badp, stp;
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: pr = 6'd8;
                1: pr = 6'd16;
                2: pr = 6'd32;
                default: pr = 6'($urandom);
            endcase
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            badp = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
            send_frame(d, pr, pen, ptyp, badp, stp, chg, -1, s);
            gap = $urandom_range(0, 3);
            tick(gap);
        end
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
